usart_receiver: RTL and testbench
=================================

Name: usart_receiver

Overview:
- Asynchronous USART receive path, clocked by i_clk.
- Consumes the receiver sample strobe from the USART clock generator: 16x bit rate in normal mode, 8x in U2X mode. The strobe is delivered as a one-cycle i_clk enable.
- Oversamples RXD, detects the start bit, majority-votes each bit, assembles 5–8 bit frames with optional parity, and presents the result in a single receive buffer with RXC/FE/PE/DOR status for the register file.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising i_rxd into i_clk domain (min 2)

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_rx_tick  input  1  one-cycle sample strobe from clock generator
- i_rxd  input  1  serial receive line, idle high, asynchronous
- i_rxen  input  1  receiver enable
- i_u2x  input  1  1: 8 samples/bit, 0: 16 samples/bit
- i_ucsz  input  2  character size: 00=5, 01=6, 10=7, 11=8 bits
- i_upm  input  2  parity: 0x=none, 10=even, 11=odd
- i_data_read  input  1  one-cycle strobe, buffer read by CPU
- o_rx_data  output  8  received character, LSB-aligned, unused MSBs zero
- o_rxc  output  1  receive complete, buffer holds unread data
- o_fe  output  1  frame error of buffered character
- o_pe  output  1  parity error of buffered character
- o_dor  output  1  data overrun
- o_busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, synchroniser flops 1 (line idle), sample counter 0.
- Synchronised line (rxs) is the last synchroniser stage. All FSM activity advances only on cycles with i_rx_tick=1.
- Sample counter S, 4 bits.
  - Bit length L: 16 (normal) or 8 (U2X).
  - Vote points: S = 7,8,9 (normal) or 3,4,5 (U2X).
  - Bit value = majority of the three votes.
  - End of bit: S = L-1. S wraps to 0.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: tick with rxs=0 → START, S=1.
  - START: majority=1 at last vote → IDLE (false start, no status change). At end of bit → DATA, bit index 0.
  - DATA: at last vote, shift majority in LSB-first. At end of bit:
    - If index = size-1 → PARITY when i_upm[1]=1, else STOP.
    - Otherwise index+1.
  - PARITY: captured at last vote.
    - Even parity: XOR of data bits and parity bit must be 0.
    - Odd parity: that XOR must be 1.
    - Transition at end of bit → STOP.
  - STOP: at last vote, frame complete → IDLE immediately (no wait for end of bit), so a start edge in the second half of the stop bit is honoured.
    - fe = (majority==0).
    - pe = parity mismatch (0 if parity disabled).
- Frame completion, on the same cycle as the STOP decision:
  - If o_rxc=0, or i_data_read=1 in that cycle: load o_rx_data/o_fe/o_pe, set o_rxc=1.
  - Else: o_dor=1; buffer, o_fe and o_pe unchanged; the new frame is discarded.
- i_data_read without completion clears o_rxc and o_dor next cycle. o_rx_data, o_fe and o_pe hold their last value.
- i_rxen=0 (sampled each i_clk): FSM → IDLE, S=0, o_rxc/o_dor cleared. o_rx_data is retained. The synchroniser keeps running.
- Changing i_u2x, i_ucsz or i_upm while o_busy=1: result undefined, not required to be checked. Encoding i_upm=01 is treated as no parity.
- Glitch rejection: a low pulse shorter than 2 votes on the start bit does not produce a frame.

Test Plan:
- 8N1, normal, tick every 4 clk, send 0x55 → o_rxc=1 after the STOP vote, o_rx_data=0x55, o_fe=0, o_pe=0, o_busy=0.
- 7E1, U2X, send 0x3A with correct parity (0) → 0x3A, pe=0. Resend with parity bit 1 → 0x3A, pe=1.
- 5-bit odd parity, send 0x1F with stop bit forced 0 → o_rx_data=0x1F, fe=1, pe=0. Upper 3 data bits read 0.
- Send 0xA5 then 0x5A without i_data_read → o_rx_data=0xA5, o_dor=1. Pulse i_data_read → o_rxc=0, o_dor=0.
- Drive rxd low for 3 ticks only (normal mode) → returns to IDLE, o_rxc stays 0. Then a valid 0xC3 frame → 0xC3 received.
- Deassert i_rxen mid-DATA, then reassert → o_busy=0, no o_rxc. Next 0x81 frame is received correctly. Async reset mid-frame gives all outputs 0.

Source files
------------

// File: rtl/usart_receiver.sv
// USART receive path: oversampled start detection, 3-vote majority per bit, 5-8 bit frames with optional parity.
// One receive buffer with RXC/FE/PE/DOR status. A new frame that arrives while the buffer is unread is dropped and flagged as overrun.
module usart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_tick,
  input  logic       i_rxd,
  input  logic       i_rxen,
  input  logic       i_u2x,
  input  logic [1:0] i_ucsz,
  input  logic [1:0] i_upm,
  input  logic       i_data_read,
  output logic [7:0] o_rx_data,
  output logic       o_rxc,
  output logic       o_fe,
  output logic       o_pe,
  output logic       o_dor,
  output logic       o_busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [2:0]             state;
  logic [3:0]             s;
  logic [2:0]             idx;
  logic                   v1, v2;
  logic [7:0]             shreg;
  logic                   pbit;

  logic [3:0] vote1, vote2, vote3, last_s;
  logic       at_v1, at_v2, at_v3, end_bit, maj, done;
  logic [2:0] size_m1;
  logic       new_pe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], i_rxd};
  end
  assign rxs = sync[SYNC_STAGES-1];

  assign vote1   = i_u2x ? 4'd3 : 4'd7;
  assign vote2   = vote1 + 4'd1;
  assign vote3   = vote1 + 4'd2;
  assign last_s  = i_u2x ? 4'd7 : 4'd15;
  assign at_v1   = (s == vote1);
  assign at_v2   = (s == vote2);
  assign at_v3   = (s == vote3);
  assign end_bit = (s == last_s);
  // Third vote is the live sample; the first two were latched on earlier ticks.
  assign maj     = (v1 & v2) | (v1 & rxs) | (v2 & rxs);
  assign size_m1 = {1'b1, i_ucsz};
  assign done    = i_rxen && i_rx_tick && (state == STOP) && at_v3;
  // Unused MSBs of shreg are zero, so the full XOR covers exactly the data bits.
  assign new_pe  = i_upm[1] & (^shreg ^ pbit ^ i_upm[0]);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      s     <= 4'd0;
      idx   <= 3'd0;
      v1    <= 1'b1;
      v2    <= 1'b1;
      shreg <= 8'd0;
      pbit  <= 1'b0;
    end else if (!i_rxen) begin
      state <= IDLE;
      s     <= 4'd0;
    end else if (i_rx_tick) begin
      if (state == IDLE) begin
        if (!rxs) begin
          state <= START;
          s     <= 4'd1;
          shreg <= 8'd0;
        end
      end else begin
        s <= end_bit ? 4'd0 : s + 4'd1;
        if (at_v1) v1 <= rxs;
        if (at_v2) v2 <= rxs;
        case (state)
          START: begin
            if (at_v3 && maj) begin
              state <= IDLE;
              s     <= 4'd0;
            end else if (end_bit) begin
              state <= DATA;
              idx   <= 3'd0;
            end
          end
          DATA: begin
            if (at_v3) shreg[idx] <= maj;
            if (end_bit) begin
              if (idx == size_m1) state <= i_upm[1] ? PARITY : STOP;
              else                idx   <= idx + 3'd1;
            end
          end
          PARITY: begin
            if (at_v3)   pbit  <= maj;
            if (end_bit) state <= STOP;
          end
          STOP: begin
            // Leave at the stop vote so a start edge late in the stop bit is caught.
            if (at_v3) begin
              state <= IDLE;
              s     <= 4'd0;
            end
          end
          default: begin
            state <= IDLE;
            s     <= 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_data <= 8'd0;
      o_rxc     <= 1'b0;
      o_fe      <= 1'b0;
      o_pe      <= 1'b0;
      o_dor     <= 1'b0;
    end else if (!i_rxen) begin
      o_rxc <= 1'b0;
      o_dor <= 1'b0;
    end else if (done) begin
      if (!o_rxc || i_data_read) begin
        o_rx_data <= shreg;
        o_fe      <= ~maj;
        o_pe      <= new_pe;
        o_rxc     <= 1'b1;
        if (i_data_read) o_dor <= 1'b0;
      end else begin
        o_dor <= 1'b1;
      end
    end else if (i_data_read) begin
      o_rxc <= 1'b0;
      o_dor <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usart_receiver.sv
// Scoreboard bench for usart_receiver: frames are bit-banged on rxd with the sample tick every 4 clocks.
module tb_usart_receiver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rxen = 1'b1;
  logic       u2x = 1'b0;
  logic [1:0] ucsz = 2'b11;
  logic [1:0] upm = 2'b00;
  logic       data_read = 1'b0;
  logic [7:0] rx_data;
  logic       rxc, fe, pe, dor, busy;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tcnt = 0;

  usart_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_tick(rx_tick), .i_rxd(rxd),
    .i_rxen(rxen), .i_u2x(u2x), .i_ucsz(ucsz), .i_upm(upm),
    .i_data_read(data_read), .o_rx_data(rx_data), .o_rxc(rxc),
    .o_fe(fe), .o_pe(pe), .o_dor(dor), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tcnt    = (tcnt + 1) % 4;
      rx_tick = (tcnt == 0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bit_clks();
    return (u2x ? 8 : 16) * 4;
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par_bit, input bit stop_bit);
    rxd = 1'b0;
    wait_clk(bit_clks());
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      wait_clk(bit_clks());
    end
    if (par_en) begin
      rxd = par_bit;
      wait_clk(bit_clks());
    end
    rxd = stop_bit;
    wait_clk(bit_clks());
    rxd = 1'b1;
    wait_clk(2 * bit_clks());
  endtask

  task automatic read_buf();
    data_read = 1'b1;
    wait_clk(1);
    data_read = 1'b0;
    wait_clk(1);
  endtask

  task automatic check_frame(input string name);
    exp_t e;
    int   budget = 400;
    while (!rxc && budget > 0) begin
      wait_clk(1);
      budget--;
    end
    n_checks++;
    if (!rxc) begin
      n_fail++;
      $display("FAIL %s rxc timeout: rxc=%0b required 1", name, rxc);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty: size=%0d required >0", name, sb.size());
    end else begin
      e = sb.pop_front();
      if (rx_data !== e.d) begin
        n_fail++;
        $display("FAIL %s data: got %h required %h", name, rx_data, e.d);
      end
      n_checks++;
      if (fe !== e.fe) begin
        n_fail++;
        $display("FAIL %s fe: got %0b required %0b", name, fe, e.fe);
      end
      n_checks++;
      if (pe !== e.pe) begin
        n_fail++;
        $display("FAIL %s pe: got %0b required %0b", name, pe, e.pe);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: got %0b required 0", name, busy);
    end
  endtask

  task automatic check_flags(input string name, input logic exp_rxc, input logic exp_dor,
                             input logic exp_busy);
    n_checks++;
    if (rxc !== exp_rxc) begin
      n_fail++;
      $display("FAIL %s rxc: got %0b required %0b", name, rxc, exp_rxc);
    end
    n_checks++;
    if (dor !== exp_dor) begin
      n_fail++;
      $display("FAIL %s dor: got %0b required %0b", name, dor, exp_dor);
    end
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL %s busy: got %0b required %0b", name, busy, exp_busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({rx_data, rxc, fe, pe, dor, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL %s outputs: data=%h rxc=%0b fe=%0b pe=%0b dor=%0b busy=%0b required all 0",
               name, rx_data, rxc, fe, pe, dor, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_clk(8);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_8n1();
    u2x = 1'b0; ucsz = 2'b11; upm = 2'b00;
    sb.push_back('{d: 8'h55, fe: 1'b0, pe: 1'b0});
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    check_frame("8n1_55");
    read_buf();
    check_flags("8n1_read", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_7e1_u2x();
    u2x = 1'b1; ucsz = 2'b10; upm = 2'b10;
    sb.push_back('{d: 8'h3A, fe: 1'b0, pe: 1'b0});
    send_frame(8'h3A, 7, 1'b1, 1'b0, 1'b1);
    check_frame("7e1_good");
    read_buf();
    sb.push_back('{d: 8'h3A, fe: 1'b0, pe: 1'b1});
    send_frame(8'h3A, 7, 1'b1, 1'b1, 1'b1);
    check_frame("7e1_bad_parity");
    read_buf();
  endtask

  task automatic test_5o1_fe();
    u2x = 1'b0; ucsz = 2'b00; upm = 2'b11;
    // Five ones already give an odd XOR, so the correct odd parity bit is 0.
    sb.push_back('{d: 8'h1F, fe: 1'b1, pe: 1'b0});
    send_frame(8'hFF, 5, 1'b1, 1'b0, 1'b0);
    check_frame("5o1_stop_low");
    read_buf();
  endtask

  task automatic test_overrun();
    u2x = 1'b0; ucsz = 2'b11; upm = 2'b00;
    sb.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    check_frame("overrun_keep_first");
    check_flags("overrun_flags", 1'b1, 1'b1, 1'b0);
    read_buf();
    check_flags("overrun_read", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    u2x = 1'b0; ucsz = 2'b11; upm = 2'b00;
    rxd = 1'b0;
    wait_clk(3 * 4);
    rxd = 1'b1;
    wait_clk(2 * bit_clks());
    check_flags("glitch_reject", 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'hC3, fe: 1'b0, pe: 1'b0});
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    check_frame("after_glitch_c3");
    read_buf();
  endtask

  task automatic test_rxen();
    u2x = 1'b0; ucsz = 2'b11; upm = 2'b00;
    rxd = 1'b0;
    wait_clk(bit_clks());
    rxd = 1'b1;
    wait_clk(bit_clks());
    check_flags("rxen_mid_data_busy", 1'b0, 1'b0, 1'b1);
    rxen = 1'b0;
    wait_clk(10);
    check_flags("rxen_off", 1'b0, 1'b0, 1'b0);
    rxen = 1'b1;
    wait_clk(3 * bit_clks());
    check_flags("rxen_back", 1'b0, 1'b0, 1'b0);
    sb.push_back('{d: 8'h81, fe: 1'b0, pe: 1'b0});
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    check_frame("rxen_81");
  endtask

  task automatic test_async_reset();
    rxd = 1'b0;
    wait_clk(2 * bit_clks());
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_mid_frame");
    rxd = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    check_all_zero("after_async_reset");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1_u2x();
    test_5o1_fe();
    test_overrun();
    test_glitch();
    test_rxen();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
